fetch_decode_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register of the Proyecto_2 core.
- Holds the PC, requests instruction words from instruction memory over a req/ready handshake, and buffers one word when decode stalls.
- Presents the immediate field and immediate-class select to the Extend stage downstream.
- Accepts branch redirects computed from the 19-bit extended immediate.

---
 rtl/fetch_decode_stage_if.sv | 18 +
 rtl/fetch_decode_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory fetch handshake between fetch_decode_stage and imem.
//   imem_req   : fetch request, held until imem_ready
//   imem_addr  : word address of the request
//   imem_ready : response valid, imem_rdata sampled in the same cycle
//   imem_rdata : instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_decode_stage_if #(
  parameter int PC_W    = 19,
  parameter int INSTR_W = 20
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, fetches words over the imem req/ready handshake, buffers one
// word in a skid register while decode stalls, and accepts branch redirects.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem (master)     : imem_req/imem_addr out, imem_ready/imem_rdata in
//   stall             : decode cannot accept, ID register holds
//   flush             : squash ID register and skid, PC unchanged
//   branch_taken/_target : redirect fetch (highest priority, not in IDLE)
//   id_valid/id_instr/id_pc : IF/ID register
//   id_imm/id_imm_src : immediate field and class select for Extend
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_stall counters
// (32-bit, saturating).
module fetch_decode_stage #(
  parameter int              PC_W     = 19,
  parameter int              INSTR_W  = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_decode_stage_if.master  imem,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [PC_W-1:0]       branch_target,
  output logic                  id_valid,
  output logic [INSTR_W-1:0]    id_instr,
  output logic [PC_W-1:0]       id_pc,
  output logic [14:0]           id_imm,
  output logic [1:0]            id_imm_src
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;

  logic accept;
  logic redirect;
  logic id_load;

  assign accept   = (state_q == S_FETCH) && imem.imem_ready;
  assign redirect = branch_taken && (state_q != S_IDLE);
  // ID register loads from memory (free ID) or from the skid (stall released);
  // flush and redirect discard whatever would have been loaded.
  assign id_load  = !stall && !flush && !redirect &&
                    (accept || (state_q == S_HOLD));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;

    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (accept) begin
          pc_d = pc_q + PC_W'(1);
          if (stall) begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD:  if (!stall) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (id_load) begin
      id_valid_d = 1'b1;
      id_instr_d = (state_q == S_HOLD) ? skid_instr_q : imem.imem_rdata;
      id_pc_d    = (state_q == S_HOLD) ? skid_pc_q    : pc_q;
    end

    // Skid occupancy is implied by S_HOLD, so leaving HOLD clears it.
    if (flush) begin
      id_valid_d = 1'b0;
      if (state_d == S_HOLD) state_d = S_FETCH;
    end

    if (redirect) begin
      pc_d       = branch_target;
      id_valid_d = 1'b0;
      state_d    = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_imm         = id_instr_q[14:0];
  assign id_imm_src     = id_instr_q[INSTR_W-1 -: 2];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (id_load && (perf_fetched_q != '1))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (stall && id_valid_q && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
